descriptor_fetch_master: RTL and testbench

- Avalon-MM master that walks a chain of 4-word DMA descriptors held in the on-chip descriptor memory (1024 x 32, single port, byte-enabled).
- Reads each descriptor and presents it to a downstream DMA engine on a valid/ready interface.
- After the descriptor is accepted, writes back its control word with the OWN bit cleared.
- Sits between the descriptor memory slave port and the DMA datapath control logic.

---
 rtl/descriptor_fetch_master.sv | 207 ++++++++++++++++++++
 tb/tb_descriptor_fetch_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/descriptor_fetch_master.sv
// Avalon-MM master that walks a chain of 4-word DMA descriptors, presents each
// downstream on desc_valid/desc_ready and writes back its control word with OWN cleared.
module descriptor_fetch_master #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  start_addr,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   stopped_unowned,
   output logic                   aborted,
   output logic [COUNT_WIDTH-1:0] desc_count,
   output logic                   desc_valid,
   input  logic                   desc_ready,
   output logic [31:0]            desc_src,
   output logic [31:0]            desc_dst,
   output logic [31:0]            desc_len,
   output logic [31:0]            desc_ctrl,
   output logic [ADDR_WIDTH-1:0]  mem_address,
   output logic                   mem_chipselect,
   output logic                   mem_write,
   output logic [3:0]             mem_byteenable,
   output logic [31:0]            mem_writedata,
   output logic                   mem_clken,
   input  logic [31:0]            mem_readdata
);

   // Handshake: a descriptor transfers at any edge where desc_valid and desc_ready
   // are both high; desc_* stay stable while desc_valid is high, and desc_valid only
   // falls after the transfer or on abort.
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_PRESENT,
      S_WRITEBACK
   } state_t;

   state_t                         state_q, state_d;
   logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d;
   logic [1:0]                     rd_idx_q, rd_idx_d;
   logic [3:0][31:0]               word_q, word_d;
   logic                           cap3_q, cap3_d;
   logic [COUNT_WIDTH-1:0]         count_q, count_d;
   logic                           done_q, done_d;
   logic                           unowned_q, unowned_d;
   logic                           aborted_q, aborted_d;
   logic [READ_LATENCY-1:0]        tag_vld_q, tag_vld_d;
   logic [READ_LATENCY-1:0][1:0]   tag_idx_q, tag_idx_d;
   logic                           issue;
   logic                           flush;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rd_idx_d  = rd_idx_q;
      word_d    = word_q;
      cap3_d    = cap3_q;
      count_d   = count_q;
      done_d    = 1'b0;
      unowned_d = unowned_q;
      aborted_d = aborted_q;
      issue     = 1'b0;
      flush     = 1'b0;

      // The oldest tag marks which descriptor word is on mem_readdata this cycle.
      if (tag_vld_q[READ_LATENCY-1]) begin
         word_d[tag_idx_q[READ_LATENCY-1]] = mem_readdata;
         if (tag_idx_q[READ_LATENCY-1] == 2'd3) cap3_d = 1'b1;
      end

      if (abort && (state_q inside {S_READ, S_DRAIN, S_PRESENT})) begin
         flush     = 1'b1;
         aborted_d = 1'b1;
         state_d   = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  ptr_d     = start_addr & ~ADDR_WIDTH'(3);
                  count_d   = '0;
                  unowned_d = 1'b0;
                  aborted_d = 1'b0;
                  rd_idx_d  = 2'd0;
                  cap3_d    = 1'b0;
                  state_d   = S_READ;
               end
            end
            S_READ: begin
               issue    = 1'b1;
               rd_idx_d = rd_idx_q + 2'd1;
               if (rd_idx_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (cap3_q) begin
                  if (word_q[3][31]) begin
                     state_d = S_PRESENT;
                  end else begin
                     done_d    = 1'b1;
                     unowned_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               end
            end
            S_PRESENT: begin
               if (desc_ready) begin
                  count_d = count_q + 1'b1;
                  state_d = S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               if (abort) begin
                  aborted_d = 1'b1;
                  state_d   = S_IDLE;
               end else if (word_q[3][30]) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ptr_d    = ptr_q + ADDR_WIDTH'(4);
                  rd_idx_d = 2'd0;
                  cap3_d   = 1'b0;
                  state_d  = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      tag_vld_d    = tag_vld_q;
      tag_idx_d    = tag_idx_q;
      tag_vld_d[0] = issue;
      tag_idx_d[0] = rd_idx_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_idx_d[i] = tag_idx_q[i-1];
      end
      if (flush) tag_vld_d = '0;
   end

   // Bus strobes are masked during reset so a mid-walk reset never issues an access.
   always_comb begin
      mem_address    = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_byteenable = 4'h0;
      mem_writedata  = 32'h0;
      if (!reset) begin
         if (state_q == S_READ) begin
            mem_chipselect = 1'b1;
            mem_byteenable = 4'hF;
            mem_address    = ptr_q + ADDR_WIDTH'(rd_idx_q);
         end else if (state_q == S_WRITEBACK) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = 4'b1000;
            mem_address    = ptr_q + ADDR_WIDTH'(3);
            mem_writedata  = {1'b0, word_q[3][30:0]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         rd_idx_q  <= '0;
         word_q    <= '0;
         cap3_q    <= 1'b0;
         count_q   <= '0;
         done_q    <= 1'b0;
         unowned_q <= 1'b0;
         aborted_q <= 1'b0;
         tag_vld_q <= '0;
         tag_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rd_idx_q  <= rd_idx_d;
         word_q    <= word_d;
         cap3_q    <= cap3_d;
         count_q   <= count_d;
         done_q    <= done_d;
         unowned_q <= unowned_d;
         aborted_q <= aborted_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign stopped_unowned = unowned_q;
   assign aborted         = aborted_q;
   assign desc_count      = count_q;
   assign desc_valid      = (state_q == S_PRESENT);
   assign desc_src        = word_q[0];
   assign desc_dst        = word_q[1];
   assign desc_len        = word_q[2];
   assign desc_ctrl       = word_q[3];
   assign mem_clken       = 1'b1;

endmodule

// File: tb/tb_descriptor_fetch_master.sv
// Bench for descriptor_fetch_master: descriptor memory model, chain-walk reference
// model feeding expected queues, and negedge monitors that pop and compare.
module tb_descriptor_fetch_master;
   localparam int AW = 10;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset, start, abort;
   logic [AW-1:0] start_addr;
   logic          busy, done, stopped_unowned, aborted, desc_valid, desc_ready;
   logic [CW-1:0] desc_count;
   logic [31:0]   desc_src, desc_dst, desc_len, desc_ctrl;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [3:0]    mem_byteenable;
   logic [31:0]   mem_writedata;
   logic [31:0]   mem_readdata = 32'h0;

   logic [31:0]   mem [0:1023];
   logic [127:0]  desc_exp_q[$];
   logic [41:0]   wr_exp_q[$];
   logic [AW-1:0] rd_exp_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int accept_cyc = -10;
   int done_seen = 0;
   int done_base = 0;
   int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
   logic rnd_rdy = 1'b1;

   assign desc_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rnd_rdy : 1'b0;

   descriptor_fetch_master #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .abort(abort),
      .busy(busy), .done(done), .stopped_unowned(stopped_unowned), .aborted(aborted),
      .desc_count(desc_count), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_ctrl(desc_ctrl),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // slave memory, read latency 1
   always @(posedge clk) begin
      if (mem_chipselect && !mem_write) mem_readdata <= mem[mem_address];
      if (mem_chipselect && mem_write)
         for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) mem[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitors
   logic [127:0] de;
   logic [41:0]  we;
   always @(negedge clk) begin
      if (desc_valid && !reset) begin
         if (desc_exp_q.size() == 0) chk("desc_unexpected", 1, 0);
         else begin
            de = desc_exp_q[0];
            chk("desc_src_dst", {desc_src, desc_dst}, de[127:64]);
            chk("desc_len_ctrl", {desc_len, desc_ctrl}, de[63:0]);
            if (desc_ready && !abort) begin
               void'(desc_exp_q.pop_front());
               accept_cyc = cyc;
            end
         end
      end
      if (mem_chipselect && !mem_write) begin
         if (rd_exp_q.size() == 0) chk("rd_unexpected", {54'h0, mem_address}, 64'hFFFF);
         else chk("rd_addr", mem_address, rd_exp_q.pop_front());
         chk("rd_be", mem_byteenable, 4'hF);
      end
      if (mem_chipselect && mem_write) begin
         if (wr_exp_q.size() == 0) chk("wr_unexpected", {mem_address, mem_writedata}, 0);
         else begin
            we = wr_exp_q.pop_front();
            chk("wr_addr_data", {mem_address, mem_writedata}, we);
         end
         chk("wr_be", mem_byteenable, 4'b1000);
         chk("wr_after_accept", 64'(cyc), 64'(accept_cyc + 1));
      end
      if (done) done_seen++;
   end

   // reference model: walk the chain as it sits in memory before the run
   task automatic predict(input logic [AW-1:0] sa, output int n, output bit un);
      int p;
      logic [31:0] c;
      p  = int'(sa) / 4 * 4;
      n  = 0;
      un = 1'b0;
      for (int d = 0; d < 64; d++) begin
         for (int k = 0; k < 4; k++) rd_exp_q.push_back(AW'(p + k));
         c = mem[p+3];
         if (!c[31]) begin
            un = 1'b1;
            break;
         end
         desc_exp_q.push_back({mem[p], mem[p+1], mem[p+2], c});
         wr_exp_q.push_back({AW'(p + 3), c & 32'h7FFF_FFFF});
         n++;
         if (c[30]) break;
         p = (p + 4) % 1024;
      end
   endtask

   task automatic put_desc(input int p, input logic [31:0] s, d, l, c);
      mem[p] = s; mem[p+1] = d; mem[p+2] = l; mem[p+3] = c;
   endtask

   // driver tasks
   task automatic pulse_start(input logic [AW-1:0] sa);
      @(posedge clk); #1;
      start = 1'b1; start_addr = sa; done_base = done_seen;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!desc_valid && k < 100) begin @(posedge clk); #1; k++; end
      chk("valid_timeout", desc_valid, 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 400) begin @(posedge clk); #1; k++; end
      chk("walk_timeout", busy, 0);
      @(negedge clk); @(posedge clk); #1;
   endtask

   task automatic end_checks(input int n, input bit un, input int nd, input bit ab);
      chk("done_pulses", done_seen - done_base, nd);
      chk("desc_count", desc_count, n);
      chk("stopped_unowned", stopped_unowned, un);
      chk("aborted", aborted, ab);
      chk("desc_left", desc_exp_q.size(), 0);
      chk("wr_left", wr_exp_q.size(), 0);
      chk("rd_left", rd_exp_q.size(), 0);
   endtask

   int n, k, base, len, stop, p;
   bit un;
   logic [31:0] c;
   logic [AW-1:0] sa;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flags", {busy, done, stopped_unowned, aborted, desc_valid, mem_chipselect, mem_write, mem_clken}, 8'h01);
      chk("rst_count", desc_count, 0);
      chk("rst_bus", {mem_address, mem_byteenable, mem_writedata}, 0);
      reset = 1'b0;

      // single descriptor, latency from start
      put_desc(16'h010, 32'h1000, 32'h2000, 32'h40, 32'hC000_0000);
      predict(10'h010, n, un);
      rdy_mode = 0;
      pulse_start(10'h010);
      k = 0;
      while (!desc_valid && k < 50) begin @(posedge clk); #1; k++; end
      chk("valid_latency", k, 6);
      wait_idle();
      end_checks(n, un, 1, 0);
      chk("ctrl_written_back", mem[10'h013], 32'h4000_0000);

      // abort while idle does nothing
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("idle_abort", {busy, aborted}, 0);

      // three-descriptor chain wrapping past the top of memory
      put_desc(32'h3F8, 32'hA0, 32'hB0, 32'h10, 32'h8000_0001);
      put_desc(32'h3FC, 32'hA1, 32'hB1, 32'h11, 32'h8000_0002);
      put_desc(32'h000, 32'hA2, 32'hB2, 32'h12, 32'hC000_0003);
      predict(10'h3F8, n, un);
      rdy_mode = 1;
      pulse_start(10'h3F8);
      wait_idle();
      end_checks(n, un, 1, 0);

      // unowned second descriptor
      put_desc(32'h040, 32'h11, 32'h22, 32'h33, 32'h8000_0000);
      put_desc(32'h044, 32'h44, 32'h55, 32'h66, 32'h0000_0000);
      predict(10'h040, n, un);
      rdy_mode = 0;
      pulse_start(10'h041);
      wait_idle();
      end_checks(n, un, 1, 0);

      // backpressure, with a start ignored while busy
      put_desc(32'h100, 32'hDEAD, 32'hBEEF, 32'h80, 32'hC000_0005);
      put_desc(32'h200, 32'h1, 32'h2, 32'h3, 32'hC000_0006);
      predict(10'h100, n, un);
      rdy_mode = 2;
      pulse_start(10'h100);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         start = (i == 3);
         start_addr = 10'h200;
      end
      start = 1'b0;
      rdy_mode = 0;
      wait_idle();
      end_checks(n, un, 1, 0);

      // abort in PRESENT coincident with desc_ready, on the second descriptor
      put_desc(32'h080, 32'h501, 32'h601, 32'h701, 32'h8000_0010);
      put_desc(32'h084, 32'h502, 32'h602, 32'h702, 32'hC000_0011);
      predict(10'h080, n, un);
      void'(wr_exp_q.pop_back());
      rdy_mode = 2;
      pulse_start(10'h080);
      wait_valid();
      rdy_mode = 0;
      @(posedge clk); #1 rdy_mode = 2;
      wait_valid();
      rdy_mode = 0; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; rdy_mode = 2;
      chk("abort_valid_drop", desc_valid, 0);
      chk("abort_idle", busy, 0);
      @(negedge clk); @(posedge clk); #1;
      chk("abort_left_desc", desc_exp_q.size(), 1);
      desc_exp_q.delete();
      end_checks(1, 0, 0, 1);
      rdy_mode = 0;

      // reset while reading; new start clears aborted
      put_desc(32'h300, 32'h9, 32'h8, 32'h7, 32'hC000_0000);
      rd_exp_q.push_back(10'h300);
      rd_exp_q.push_back(10'h301);
      pulse_start(10'h300);
      chk("start_clears_aborted", aborted, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_flags", {busy, done, stopped_unowned, aborted, desc_valid, mem_chipselect, mem_write, mem_clken}, 8'h01);
      chk("midrst_desc", {desc_src, desc_dst}, 0);
      chk("midrst_count", desc_count, 0);
      reset = 1'b0;
      chk("midrst_rd_left", rd_exp_q.size(), 0);

      // randomized chains
      for (int r = 0; r < 25; r++) begin
         base = $urandom_range(0, 255) * 4;
         len  = $urandom_range(1, 4);
         stop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         for (int i = 0; i < len; i++) begin
            p = (base + 4 * i) % 1024;
            c = {1'b1, (i == len - 1), 30'($urandom)};
            if (i == stop) c[31] = 1'b0;
            put_desc(p, $urandom, $urandom, $urandom, c);
         end
         sa = AW'(base + $urandom_range(0, 3));
         predict(sa, n, un);
         rdy_mode = $urandom_range(0, 1);
         pulse_start(sa);
         wait_idle();
         end_checks(n, un, 1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
